// File: rtl/unpack_1d_stream_to_3d_sub_array.sv
// Rebuilds a ROWS x COLS array from a sub-block-major element stream and
// presents the completed frame with a valid/ready handshake.
module unpack_1d_stream_to_3d_sub_array #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int SUB_ROWS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [BIT_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BIT_WIDTH-1:0] out [ROWS-1:0][COLS-1:0],
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int LOWER_ROWS = ROWS - SUB_ROWS;
    localparam bit HAS_LOWER  = (LOWER_ROWS > 0);
    localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W      = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [ROW_W-1:0] UPPER_LAST = ROW_W'(SUB_ROWS - 1);
    localparam logic [ROW_W-1:0] LOWER_LAST = ROW_W'(HAS_LOWER ? LOWER_ROWS - 1 : 0);
    localparam logic [ROW_W-1:0] LOWER_OFF  = ROW_W'(HAS_LOWER ? SUB_ROWS : 0);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);

    typedef enum logic {
        S_FILL,
        S_FULL
    } state_e;

    state_e               state_q, state_d;
    logic                 lower_q, lower_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [ROW_W-1:0]     wr_row;
    logic                 accept;
    logic                 row_wrap;
    logic                 col_wrap;
    logic                 frame_end;
    logic [BIT_WIDTH-1:0] out_q [ROWS-1:0][COLS-1:0];

    assign in_ready  = (state_q == S_FILL);
    assign out_valid = (state_q == S_FULL);
    assign accept    = in_ready && in_valid && !clear;

    // Row counter is block-relative; the LOWER phase is shifted down by SUB_ROWS.
    assign row_wrap  = (row_q == (lower_q ? LOWER_LAST : UPPER_LAST));
    assign col_wrap  = (col_q == COL_LAST);
    assign frame_end = row_wrap && col_wrap && (lower_q || !HAS_LOWER);
    assign wr_row    = lower_q ? row_q + LOWER_OFF : row_q;

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d = state_q;
        lower_d = lower_q;
        row_d   = row_q;
        col_d   = col_q;
        if (clear) begin
            state_d = S_FILL;
            lower_d = 1'b0;
            row_d   = '0;
            col_d   = '0;
        end else if (state_q == S_FULL) begin
            if (out_ready) begin
                state_d = S_FILL;
                lower_d = 1'b0;
                row_d   = '0;
                col_d   = '0;
            end
        end else if (in_valid) begin
            if (frame_end) begin
                state_d = S_FULL;
                lower_d = 1'b0;
                row_d   = '0;
                col_d   = '0;
            end else if (row_wrap) begin
                row_d = '0;
                if (col_wrap) begin
                    col_d   = '0;
                    lower_d = 1'b1;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end else begin
                row_d = row_q + ROW_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FILL;
            lower_q <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            lower_q <= lower_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // NOTE: the array is reset because a zeroed out is visible after reset;
    // between frames it is only ever overwritten on accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    out_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            out_q[wr_row][col_q] <= in_data;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_unpack_1d_stream_to_3d_sub_array.sv
// Directed bench: default 8x8/4 geometry plus the SUB_ROWS=ROWS and SUB_ROWS=1 corners.
module tb_unpack_1d_stream_to_3d_sub_array;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       out_ready;
    logic       in_valid;
    logic [7:0] in_data;

    logic       in_ready0, out_valid0;
    logic       in_ready1, out_valid1;
    logic       in_ready2, out_valid2;
    logic [7:0] out0 [7:0][7:0];
    logic [7:0] out1 [7:0][7:0];
    logic [7:0] out2 [3:0][3:0];

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    unpack_1d_stream_to_3d_sub_array #(.BIT_WIDTH(8), .ROWS(8), .COLS(8), .SUB_ROWS(4)) dut0 (
        .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .out(out0), .out_valid(out_valid0), .out_ready(out_ready));

    unpack_1d_stream_to_3d_sub_array #(.BIT_WIDTH(8), .ROWS(8), .COLS(8), .SUB_ROWS(8)) dut1 (
        .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .out(out1), .out_valid(out_valid1), .out_ready(out_ready));

    unpack_1d_stream_to_3d_sub_array #(.BIT_WIDTH(8), .ROWS(4), .COLS(4), .SUB_ROWS(1)) dut2 (
        .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready2), .out(out2), .out_valid(out_valid2), .out_ready(out_ready));

    // Beat index that lands in out[i][j] for the default 8x8, SUB_ROWS=4 geometry.
    function automatic int exp_idx(input int i, input int j);
        return (i < 4) ? j * 4 + i : 32 + j * 4 + (i - 4);
    endfunction

    function automatic logic ready_of(input int sel);
        return (sel == 0) ? in_ready0 : (sel == 1) ? in_ready1 : in_ready2;
    endfunction

    function automatic int count_nonzero0();
        int n = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (out0[i][j] !== 8'h00) n++;
        return n;
    endfunction

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic push(input int sel, input logic [7:0] d);
        int   guard = 0;
        logic rdy;
        in_data  = d;
        in_valid = 1'b1;
        rdy = ready_of(sel);
        while (!rdy && guard < 200) begin
            @(negedge clk);
            guard++;
            rdy = ready_of(sel);
        end
        if (!rdy) begin
            checks_total++;
            $display("FAIL push_timeout dut%0d: in_ready=0 after %0d cycles, required 1", sel, guard);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks_total++; if (in_ready0 !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready0); else checks_passed++;
        checks_total++; if (out_valid0 !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid0); else checks_passed++;
        checks_total++; if (count_nonzero0() !== 0) $display("FAIL rst_out_zero: %0d nonzero elements, want 0", count_nonzero0()); else checks_passed++;
        rst = 1'b0;
        @(negedge clk);
        checks_total++; if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) $display("FAIL rst_dut2: in_ready=%b out_valid=%b want 1/0", in_ready2, out_valid2); else checks_passed++;
    endtask

    task automatic test_basic_frame();
        int pr[9] = '{0, 1, 3, 0, 3, 4, 7, 4, 7};
        int pc[9] = '{0, 0, 0, 1, 7, 0, 0, 1, 7};
        int pv[9] = '{0, 1, 3, 4, 31, 32, 35, 36, 63};
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (k == 63) begin
                checks_total++; if (out_valid0 !== 1'b0) $display("FAIL basic_valid_early: got %b want 0", out_valid0); else checks_passed++;
            end
            push(0, 8'(k));
        end
        checks_total++; if (out_valid0 !== 1'b1) $display("FAIL basic_valid_rise: got %b want 1", out_valid0); else checks_passed++;
        checks_total++; if (in_ready0 !== 1'b0) $display("FAIL basic_in_ready_full: got %b want 0", in_ready0); else checks_passed++;
        for (int p = 0; p < 9; p++) begin
            checks_total++;
            if (out0[pr[p]][pc[p]] !== 8'(pv[p]))
                $display("FAIL basic_out[%0d][%0d]: got %0d want %0d", pr[p], pc[p], out0[pr[p]][pc[p]], pv[p]);
            else checks_passed++;
        end
        @(negedge clk);
        checks_total++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) $display("FAIL basic_valid_one_cycle: out_valid=%b in_ready=%b want 0/1", out_valid0, in_ready0); else checks_passed++;
    endtask

    task automatic test_backpressure();
        int bad = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 64; k++) push(0, 8'(64 + k));
        in_data  = 8'hAA;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks_total++; if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1) $display("FAIL bp_hold cycle %0d: in_ready=%b out_valid=%b want 0/1", c, in_ready0, out_valid0); else checks_passed++;
        end
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (out0[i][j] !== 8'(64 + exp_idx(i, j))) bad++;
        checks_total++; if (bad != 0) $display("FAIL bp_out_stable: %0d elements differ, want 0", bad); else checks_passed++;
        out_ready = 1'b1;
        @(negedge clk);
        checks_total++; if (out_valid0 !== 1'b0 || out0[0][0] !== 8'd64) $display("FAIL bp_release: out_valid=%b out[0][0]=%0h want 0/40", out_valid0, out0[0][0]); else checks_passed++;
        @(negedge clk);
        checks_total++; if (out0[0][0] !== 8'hAA) $display("FAIL bp_first_beat: out[0][0]=%0h want aa", out0[0][0]); else checks_passed++;
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks_total++; if (out0[0][0] !== 8'hAA) $display("FAIL bp_clear_keeps: out[0][0]=%0h want aa", out0[0][0]); else checks_passed++;
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b1;
        for (int k = 0; k <= 20; k++) push(0, 8'(k));
        rst = 1'b1;
        @(negedge clk);
        checks_total++; if (count_nonzero0() !== 0) $display("FAIL rstmid_out_zero: %0d nonzero elements, want 0", count_nonzero0()); else checks_passed++;
        checks_total++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) $display("FAIL rstmid_flags: out_valid=%b in_ready=%b want 0/1", out_valid0, in_ready0); else checks_passed++;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 64; k++) push(0, 8'(100 + k));
        checks_total++; if (out_valid0 !== 1'b1) $display("FAIL rstmid_valid: got %b want 1", out_valid0); else checks_passed++;
        checks_total++; if (out0[0][0] !== 8'd100) $display("FAIL rstmid_out[0][0]: got %0d want 100", out0[0][0]); else checks_passed++;
        checks_total++; if (out0[4][0] !== 8'd132) $display("FAIL rstmid_out[4][0]: got %0d want 132", out0[4][0]); else checks_passed++;
        checks_total++; if (out0[7][7] !== 8'd163) $display("FAIL rstmid_out[7][7]: got %0d want 163", out0[7][7]); else checks_passed++;
        @(negedge clk);
    endtask

    task automatic test_bubbles();
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            if (k == 63) begin
                checks_total++; if (out_valid0 !== 1'b0) $display("FAIL bub_valid_early: got %b want 0", out_valid0); else checks_passed++;
            end
            push(0, 8'(k));
        end
        checks_total++; if (out_valid0 !== 1'b1) $display("FAIL bub_valid_rise: got %b want 1", out_valid0); else checks_passed++;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                checks_total++;
                if (out0[i][j] !== 8'(exp_idx(i, j)))
                    $display("FAIL bub_out[%0d][%0d]: got %0d want %0d", i, j, out0[i][j], exp_idx(i, j));
                else checks_passed++;
            end
        @(negedge clk);
    endtask

    task automatic test_clear_mid();
        out_ready = 1'b0;
        for (int k = 0; k <= 20; k++) push(0, 8'(200 + k));
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        checks_total++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) $display("FAIL clr_flags: out_valid=%b in_ready=%b want 0/1", out_valid0, in_ready0); else checks_passed++;
        checks_total++; if (out0[0][0] !== 8'd200) $display("FAIL clr_out[0][0]: got %0d want 200", out0[0][0]); else checks_passed++;
        checks_total++; if (out0[0][5] !== 8'd220) $display("FAIL clr_out[0][5]: got %0d want 220", out0[0][5]); else checks_passed++;
        checks_total++; if (out0[1][5] !== 8'd21) $display("FAIL clr_dropped_beat: out[1][5]=%0d want 21", out0[1][5]); else checks_passed++;
        push(0, 8'd100);
        checks_total++; if (out0[0][0] !== 8'd100 || out0[1][0] !== 8'd201) $display("FAIL clr_restart: out[0][0]=%0d out[1][0]=%0d want 100/201", out0[0][0], out0[1][0]); else checks_passed++;
        for (int k = 1; k < 64; k++) push(0, 8'(100 + k));
        checks_total++; if (out_valid0 !== 1'b1) $display("FAIL clr_valid: got %b want 1", out_valid0); else checks_passed++;
        checks_total++; if (out0[4][0] !== 8'd132) $display("FAIL clr_out[4][0]: got %0d want 132", out0[4][0]); else checks_passed++;
        checks_total++; if (out0[7][7] !== 8'd163) $display("FAIL clr_out[7][7]: got %0d want 163", out0[7][7]); else checks_passed++;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks_total++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) $display("FAIL clr_full_drop: out_valid=%b in_ready=%b want 0/1", out_valid0, in_ready0); else checks_passed++;
        checks_total++; if (out0[7][7] !== 8'd163) $display("FAIL clr_full_keep: out[7][7]=%0d want 163", out0[7][7]); else checks_passed++;
    endtask

    task automatic test_full_sub();
        apply_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (k == 63) begin
                checks_total++; if (out_valid1 !== 1'b0) $display("FAIL full_valid_early: got %b want 0", out_valid1); else checks_passed++;
            end
            push(1, 8'(k));
        end
        checks_total++; if (out_valid1 !== 1'b1) $display("FAIL full_valid_rise: got %b want 1", out_valid1); else checks_passed++;
        checks_total++; if (out1[7][7] !== 8'd63) $display("FAIL full_out[7][7]: got %0d want 63", out1[7][7]); else checks_passed++;
        checks_total++; if (out1[5][2] !== 8'd21) $display("FAIL full_out[5][2]: got %0d want 21", out1[5][2]); else checks_passed++;
        checks_total++; if (out1[0][1] !== 8'd8) $display("FAIL full_out[0][1]: got %0d want 8", out1[0][1]); else checks_passed++;
        checks_total++; if (out1[7][0] !== 8'd7) $display("FAIL full_out[7][0]: got %0d want 7", out1[7][0]); else checks_passed++;
    endtask

    task automatic test_single_sub();
        int pr[5] = '{1, 3, 1, 3, 2};
        int pc[5] = '{0, 0, 1, 3, 2};
        int pv[5] = '{4, 6, 7, 15, 11};
        apply_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k == 15) begin
                checks_total++; if (out_valid2 !== 1'b0) $display("FAIL single_valid_early: got %b want 0", out_valid2); else checks_passed++;
            end
            push(2, 8'(k));
        end
        checks_total++; if (out_valid2 !== 1'b1) $display("FAIL single_valid_rise: got %b want 1", out_valid2); else checks_passed++;
        for (int j = 0; j < 4; j++) begin
            checks_total++; if (out2[0][j] !== 8'(j)) $display("FAIL single_out[0][%0d]: got %0d want %0d", j, out2[0][j], j); else checks_passed++;
        end
        for (int p = 0; p < 5; p++) begin
            checks_total++;
            if (out2[pr[p]][pc[p]] !== 8'(pv[p]))
                $display("FAIL single_out[%0d][%0d]: got %0d want %0d", pr[p], pc[p], out2[pr[p]][pc[p]], pv[p]);
            else checks_passed++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_rst_mid();
        test_bubbles();
        test_clear_mid();
        test_full_sub();
        test_single_sub();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/unpack_1d_stream_to_3d_sub_array.md
# unpack_1d_stream_to_3d_sub_array

Receive-side counterpart of the sub-block array flattener. Accepts a stream of BIT_WIDTH elements, one per valid/ready beat, in sub-block-major order, and rebuilds the full ROWS x COLS array in registers. When the frame is complete, the block presents the rebuilt array with an output valid/ready handshake. It sits at the consumer end of any link that carries a flattened sub-block array one element at a time.

## Interface
- BIT_WIDTH, 4, element width in bits
- ROWS, 8, array rows
- COLS, 8, array columns
- SUB_ROWS, 4, rows in the upper sub-block; legal range 1 <= SUB_ROWS <= ROWS
- clk  input  1  single clock; all state is updated on its rising edge
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous abort; discards the partial frame
- in_data  input  BIT_WIDTH  stream element
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts in_data this cycle
- out  output  BIT_WIDTH per element, unpacked [ROWS-1:0][COLS-1:0]  rebuilt array
- out_valid  output  1  out holds a complete frame
- out_ready  input  1  consumer accepts the frame

## Operation
- Frame length N = ROWS*COLS elements. A beat is accepted when in_valid && in_ready.
- Stream order, where k is the 0-based beat index within a frame:
  - Phase UPPER, for k < COLS*SUB_ROWS: k = j*SUB_ROWS + i. The element goes to out[i][j], with i in 0..SUB_ROWS-1.
  - Phase LOWER, for the remaining beats: k = COLS*SUB_ROWS + j*(ROWS-SUB_ROWS) + i2. The element goes to out[i2+SUB_ROWS][j].
- Index logic uses three counters: phase, column j, and row-in-block r. r wraps at SUB_ROWS in UPPER and at ROWS-SUB_ROWS in LOWER, and j increments on each r wrap.
  - When j wraps from COLS-1 in UPPER, phase moves to LOWER.
  - When SUB_ROWS == ROWS, LOWER is skipped and the frame ends after the UPPER phase.
- No multiplier is needed in the index path; the counters are sufficient.
- State machine:
  - FILL: in_ready=1, out_valid=0. The accepted element is written into its out register. On acceptance of beat N-1, go to FULL.
  - FULL: in_ready=0, out_valid=1. out is stable. On out_valid && out_ready, go to FILL and zero the counters.
- The out registers are written only on accepted beats. They are not cleared between frames; each frame overwrites every element.
- clear: in FILL, the counters reset to 0, the element offered in the same cycle is not written, and out is unchanged. In FULL, clear drops the frame: go to FILL with out_valid=0. clear takes priority over every other event.

## Timing
- Reset (async assert, values held until the first edge after deassert): state=FILL, counters=0, every out element=0, out_valid=0, in_ready=1.
- in_ready and out_valid are decoded directly from the state register. There is no combinational path from in_valid or out_ready to in_ready or out_valid.
- Latency: out_valid rises the cycle after beat N-1 is accepted.
- in_ready returns to 1 the cycle after the out handshake. Minimum frame period is N+1 cycles.
- Bubbles (in_valid=0) stall the counters without limit. A beat offered while in FULL is not accepted and the upstream source must hold it.
- Reset asserted mid-frame discards the frame immediately.

## Test plan
- Use BIT_WIDTH=8 with the other parameters at default, and drive in_data=k for k=0..63 with out_ready=1:
  - out[0][0]=0, out[1][0]=1, out[3][0]=3, out[0][1]=4, out[3][7]=31, out[4][0]=32, out[7][0]=35, out[4][1]=36, out[7][7]=63.
  - out_valid rises exactly 1 cycle after beat 63 and lasts 1 cycle.
- Hold out_ready=0 for 10 cycles after frame completion, with in_valid=1 carrying 0xAA:
  - in_ready stays 0, out is unchanged, and 0xAA is not written.
  - After out_ready=1, the next accepted 0xAA lands in out[0][0].
- Insert random in_valid bubbles (50%) across a frame: out is identical to the bubble-free result, and out_valid rises 1 cycle after the 64th accepted beat.
- Assert rst after beat 20 (and separately clear after beat 20), then stream a fresh frame 100+k:
  - After rst, all outputs are back at their reset values before the fresh frame.
  - After clear, out still holds the partial data, out_valid stays 0, and the fresh frame's first beat lands in out[0][0].
  - For both cases the final result is out[4][0]=132 and out[7][7]=163.
- With SUB_ROWS=8 and ROWS=COLS=8: k maps to out[k%8][k/8], so out[7][7]=63. The frame ends after 64 beats with no LOWER phase.
- With SUB_ROWS=1 and ROWS=COLS=4: out[0][j]=j, and out[1][0]=4, out[3][0]=6, out[1][1]=7, out[3][3]=15.
